// File: rtl/pipe_slice_chain.sv
// Valid/ready register-slice chain with optional per-stage skid buffering,
// synchronous flush and an occupancy count of all held entries.
module pipe_slice_chain #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           STAGES     = 1,
    parameter int unsigned           SKID       = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    localparam int unsigned          CAP        = (SKID != 0) ? 2 * STAGES : STAGES,
    localparam int unsigned          OW         = (CAP == 0) ? 1 : $clog2(CAP + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_dat_o,
    output logic [OW-1:0]         occ_o
);

    if (STAGES == 0) begin : g_pass
        assign m_valid_o = s_valid_i & ~flush_i;
        assign s_ready_o = m_ready_i & ~flush_i;
        assign m_dat_o   = s_dat_i;
        assign occ_o     = '0;
    end else begin : g_chain
        logic [STAGES-1:0] main_bits;
        logic [STAGES-1:0] skid_bits;

        for (genvar i = 0; i < STAGES; i++) begin : g_stg
            logic                  in_vld;
            logic [DATA_WIDTH-1:0] in_dat;
            logic                  rdy_dn;
            logic                  rdy_up;
            logic                  main_vld;
            logic [DATA_WIDTH-1:0] main_dat;

            if (i == 0) begin : g_head
                assign in_vld = s_valid_i;
                assign in_dat = s_dat_i;
            end else begin : g_link
                assign in_vld = g_stg[i-1].main_vld;
                assign in_dat = g_stg[i-1].main_dat;
            end

            if (i == STAGES - 1) begin : g_tail
                assign rdy_dn = m_ready_i;
            end else begin : g_next
                assign rdy_dn = g_stg[i+1].rdy_up;
            end

            assign main_bits[i] = main_vld;

            if (SKID != 0) begin : g_skid
                logic                  skid_vld;
                logic [DATA_WIDTH-1:0] skid_dat;

                // Upstream ready comes straight from a flop, so no combinational
                // path from m_ready_i ever reaches s_ready_o.
                assign rdy_up       = ~skid_vld;
                assign skid_bits[i] = skid_vld;

                always_ff @(posedge clk_i or negedge rst_n_i) begin
                    if (!rst_n_i) begin
                        main_vld <= 1'b0;
                        skid_vld <= 1'b0;
                        main_dat <= RESET_VAL;
                        skid_dat <= RESET_VAL;
                    end else if (flush_i) begin
                        main_vld <= 1'b0;
                        skid_vld <= 1'b0;
                    end else if (main_vld && rdy_dn) begin
                        if (skid_vld) begin
                            main_dat <= skid_dat;
                            skid_vld <= 1'b0;
                        end else if (in_vld) begin
                            main_dat <= in_dat;
                        end else begin
                            main_vld <= 1'b0;
                        end
                    end else if (in_vld && !skid_vld) begin
                        if (main_vld) begin
                            skid_dat <= in_dat;
                            skid_vld <= 1'b1;
                        end else begin
                            main_dat <= in_dat;
                            main_vld <= 1'b1;
                        end
                    end
                end
            end else begin : g_plain
                assign rdy_up       = ~main_vld | rdy_dn;
                assign skid_bits[i] = 1'b0;

                always_ff @(posedge clk_i or negedge rst_n_i) begin
                    if (!rst_n_i) begin
                        main_vld <= 1'b0;
                        main_dat <= RESET_VAL;
                    end else if (flush_i) begin
                        main_vld <= 1'b0;
                    end else if (rdy_up) begin
                        main_vld <= in_vld;
                        if (in_vld) begin
                            main_dat <= in_dat;
                        end
                    end
                end
            end
        end

        assign m_valid_o = g_stg[STAGES-1].main_vld & ~flush_i;
        assign m_dat_o   = g_stg[STAGES-1].main_dat;
        assign s_ready_o = g_stg[0].rdy_up & ~flush_i;

        always_comb begin
            occ_o = '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                occ_o = occ_o + OW'(main_bits[k]) + OW'(skid_bits[k]);
            end
        end
    end

endmodule
